// File: rtl/fpadd_ctrl.sv
// Sequencing controller for a floating-point adder datapath: load, align, add, normalise, round.
// Optional FPADD_CTRL_CYCLE_CNT_EN adds a CycleCnt port reporting the cycles spent from LOAD to DONE.
module fpadd_ctrl (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [7:0] ExpDiff,
    input  logic       Special,
    input  logic       SumZero,
    input  logic       SumCarry,
    input  logic       SumMsb,
    input  logic       RoundCarry,
    output logic       LoadOps,
    output logic       AlignShr,
    output logic       AddEn,
    output logic       NormShl,
    output logic       NormShr,
    output logic       ExpInc,
    output logic       ExpDec,
    output logic       RoundEn,
    output logic       SpecialSel,
    output logic       Busy,
    output logic       Done
`ifdef FPADD_CTRL_CYCLE_CNT_EN
    ,
    output logic [6:0] CycleCnt
`endif
);

    // NORM is split into an evaluation cycle and shift cycles so that every
    // strobe is decoded from registered state only.
    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_NORM_SHL,
        S_NORM_SHR,
        S_ROUND,
        S_RENORM,
        S_DONE
    } state_t;

    localparam logic [4:0] ALIGN_MAX = 5'd25;
    localparam logic [4:0] NORM_MAX  = 5'd23;

    state_t     state_reg, state_next;
    logic [4:0] align_cnt_reg, align_cnt_next;
    logic [4:0] norm_cnt_reg, norm_cnt_next;
    logic       special_reg, special_next;
    logic [4:0] align_load;

    assign align_load = (ExpDiff > {3'd0, ALIGN_MAX}) ? ALIGN_MAX : ExpDiff[4:0];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg     <= S_IDLE;
            align_cnt_reg <= 5'd0;
            norm_cnt_reg  <= 5'd0;
            special_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            align_cnt_reg <= align_cnt_next;
            norm_cnt_reg  <= norm_cnt_next;
            special_reg   <= special_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        align_cnt_next = align_cnt_reg;
        norm_cnt_next  = norm_cnt_reg;
        special_next   = special_reg;
        case (state_reg)
            S_IDLE: begin
                if (Start) state_next = S_LOAD;
            end
            S_LOAD: begin
                align_cnt_next = align_load;
                norm_cnt_next  = 5'd0;
                special_next   = Special;
                if (Special)                 state_next = S_DONE;
                else if (align_load == 5'd0) state_next = S_ADD;
                else                         state_next = S_ALIGN;
            end
            S_ALIGN: begin
                align_cnt_next = align_cnt_reg - 5'd1;
                if (align_cnt_reg <= 5'd1) state_next = S_ADD;
            end
            S_ADD: state_next = S_NORM;
            S_NORM: begin
                if (SumZero)                      state_next = S_ROUND;
                else if (SumCarry)                state_next = S_NORM_SHR;
                else if (SumMsb)                  state_next = S_ROUND;
                else if (norm_cnt_reg >= NORM_MAX) state_next = S_ROUND;
                else                              state_next = S_NORM_SHL;
            end
            S_NORM_SHL: begin
                norm_cnt_next = norm_cnt_reg + 5'd1;
                state_next    = S_NORM;
            end
            S_NORM_SHR: state_next = S_ROUND;
            S_ROUND: begin
                if (RoundCarry) state_next = S_RENORM;
                else            state_next = S_DONE;
            end
            S_RENORM: state_next = S_DONE;
            S_DONE: begin
                special_next = 1'b0;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        LoadOps    = 1'b0;
        AlignShr   = 1'b0;
        AddEn      = 1'b0;
        NormShl    = 1'b0;
        NormShr    = 1'b0;
        ExpInc     = 1'b0;
        ExpDec     = 1'b0;
        RoundEn    = 1'b0;
        SpecialSel = 1'b0;
        Done       = 1'b0;
        Busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_LOAD:     LoadOps  = 1'b1;
            S_ALIGN:    AlignShr = 1'b1;
            S_ADD:      AddEn    = 1'b1;
            S_NORM_SHL: begin
                NormShl = 1'b1;
                ExpDec  = 1'b1;
            end
            S_NORM_SHR, S_RENORM: begin
                NormShr = 1'b1;
                ExpInc  = 1'b1;
            end
            S_ROUND:    RoundEn  = 1'b1;
            S_DONE: begin
                Done       = 1'b1;
                SpecialSel = special_reg;
            end
            default: ;
        endcase
    end

`ifdef FPADD_CTRL_CYCLE_CNT_EN
    logic [6:0] cycle_cnt_reg;

    // Starts at 1 while in LOAD, holds its final value from DONE until the next request.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cycle_cnt_reg <= 7'd0;
        end else if (state_reg == S_IDLE) begin
            if (state_next == S_LOAD) cycle_cnt_reg <= 7'd1;
        end else if (state_reg != S_DONE && cycle_cnt_reg != 7'd127) begin
            cycle_cnt_reg <= cycle_cnt_reg + 7'd1;
        end
    end

    assign CycleCnt = cycle_cnt_reg;
`endif

endmodule
